// File: rtl/axis_out_arbiter_pkg.sv
// Shared sizing, state encoding and sideband types for the output-stream arbiter.
package axis_out_arbiter_pkg;

    localparam int N_SRC      = 4;
    localparam int ROWS       = 4;
    localparam int WORD_WIDTH = 8;
    localparam int W_BPT      = 8;
    localparam int W_SRC      = $clog2(N_SRC);
    localparam int W_BEAT     = ROWS * WORD_WIDTH;

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // Per-beat sideband carried next to the data word.
    typedef struct packed {
        logic             last;
        logic             last_pkt;
        logic [W_BPT-1:0] bpt;
    } tuser_st;

    function automatic logic [N_SRC-1:0] src_onehot(input logic [W_SRC-1:0] idx);
        src_onehot      = '0;
        src_onehot[idx] = 1'b1;
    endfunction

    // Round-robin successor, wrapping at N_SRC even when N_SRC is not a power of two.
    function automatic logic [W_SRC-1:0] next_src(input logic [W_SRC-1:0] idx);
        if (idx == W_SRC'(N_SRC - 1)) begin
            next_src = '0;
        end else begin
            next_src = idx + 1'b1;
        end
    endfunction

endpackage

// File: rtl/axis_out_arbiter_if.sv
// Stream bundle of LANES parallel lanes sharing one sideband layout.
// The arbiter uses a N_SRC-lane instance on its input and a 1-lane instance on its output.
interface axis_out_arbiter_if #(
    parameter int LANES = 1,
    parameter int DW    = 32,
    parameter int BW    = 8
);
    logic [LANES-1:0]    valid;
    logic [LANES-1:0]    ready;
    logic [LANES*DW-1:0] data;
    logic [LANES-1:0]    last;
    logic [LANES-1:0]    last_pkt;
    logic [LANES*BW-1:0] bpt;

    modport master (
        output valid,
        output data,
        output last,
        output last_pkt,
        output bpt,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  last,
        input  last_pkt,
        input  bpt,
        output ready
    );
endinterface

// File: rtl/axis_out_arbiter_rr_pick.sv
// Combinational round-robin search: first asserted req starting at ptr, wrapping at N.
module rr_pick #(
    parameter  int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    int j;

    // Walk offsets from far to near so the closest request to ptr is the one left standing.
    always_comb begin
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                idx = W'(j);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_out_arbiter.sv
// Packet-granular round-robin arbiter merging N_SRC output-shift streams onto one DMA stream.
// A grant lasts until the winner's last beat; a layer barrier blocks any source that has
// closed its layer (last_pkt) until every source has done so.
// Sizing comes from axis_out_arbiter_pkg.
//
//   state | meaning
//   ARB   | one-cycle bubble: pick the next eligible source from rr_ptr
//   XFER  | granted source wired straight through to the output until its last beat
module axis_out_arbiter
    import axis_out_arbiter_pkg::*;
(
    input  logic                 aclk,
    input  logic                 aresetn,
    axis_out_arbiter_if.slave    s_axis,
    axis_out_arbiter_if.master   m_axis,
    output logic [W_SRC-1:0]     m_src,
    output logic                 layer_done,
    output logic                 err_bpt
);

    arb_state_t        state_q, state_d;
    logic [W_SRC-1:0]  grant_q, grant_d;
    logic [W_SRC-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N_SRC-1:0]  done_mask_q, done_mask_d;
    logic              first_q, first_d;
    logic [W_BPT-1:0]  bpt_lat_q, bpt_lat_d;
    logic              err_q, err_d;

    logic [N_SRC-1:0]  elig;
    logic [W_SRC-1:0]  pick_idx;
    logic              pick_any;
    logic              all_done;
    logic              fire;

    logic              sel_valid;
    logic [W_BEAT-1:0] sel_data;
    tuser_st           sel_user;

    // Sources that closed their layer sit out until the barrier clears them.
    assign elig     = s_axis.valid & ~done_mask_q;
    assign all_done = &done_mask_q;

    rr_pick #(.N(N_SRC)) u_pick (
        .req (elig),
        .ptr (rr_ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Pull the granted lane out of the input bundle.
    always_comb begin
        sel_valid         = s_axis.valid[grant_q];
        sel_data          = s_axis.data[int'(grant_q) * W_BEAT +: W_BEAT];
        sel_user          = '0;
        sel_user.last     = s_axis.last[grant_q];
        sel_user.last_pkt = s_axis.last_pkt[grant_q];
        sel_user.bpt      = s_axis.bpt[int'(grant_q) * W_BPT +: W_BPT];
    end

    assign fire = (state_q == XFER) & sel_valid & m_axis.ready[0];

    // Next-state: arbitration, packet close, layer bookkeeping and bpt consistency.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        done_mask_d = done_mask_q;
        first_d     = first_q;
        bpt_lat_d   = bpt_lat_q;
        err_d       = err_q;

        case (state_q)
            ARB: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    first_d = 1'b1;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (fire) begin
                    first_d = 1'b0;
                    if (first_q) begin
                        bpt_lat_d = sel_user.bpt;
                    end else if (sel_user.bpt != bpt_lat_q) begin
                        err_d = 1'b1;
                    end
                    if (sel_user.last) begin
                        state_d  = ARB;
                        rr_ptr_d = next_src(grant_q);
                        // last_pkt only counts when it arrives together with last.
                        if (sel_user.last_pkt) begin
                            done_mask_d[grant_q] = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ARB;
        endcase

        // The barrier clear wins; nothing can be granted while every source is done.
        if (all_done) begin
            done_mask_d = '0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= ARB;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            done_mask_q <= '0;
            first_q     <= 1'b0;
            bpt_lat_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            done_mask_q <= done_mask_d;
            first_q     <= first_d;
            bpt_lat_q   <= bpt_lat_d;
            err_q       <= err_d;
        end
    end

    // Zero-latency output mux; everything is held low in ARB and while reset is asserted.
    always_comb begin
        m_axis.valid    = '0;
        m_axis.data     = '0;
        m_axis.last     = '0;
        m_axis.last_pkt = '0;
        m_axis.bpt      = '0;
        s_axis.ready    = '0;
        m_src           = '0;
        if (aresetn && (state_q == XFER)) begin
            m_axis.valid[0]    = sel_valid;
            m_axis.data        = sel_data;
            m_axis.last[0]     = sel_user.last;
            m_axis.bpt         = sel_user.bpt;
            m_axis.last_pkt[0] = sel_user.last_pkt & sel_user.last
                                 & (&(done_mask_q | src_onehot(grant_q)));
            s_axis.ready       = m_axis.ready[0] ? src_onehot(grant_q) : '0;
            m_src              = grant_q;
        end
    end

    assign layer_done = aresetn & all_done;
    assign err_bpt    = aresetn & err_q;

endmodule

// File: tb/tb_axis_out_arbiter.sv
// Scoreboard bench: sources are per-lane packet queues, a packet-level model predicts the
// grant sequence, handshakes and flags, and a separate monitor checks every output beat.
module tb_axis_out_arbiter;
    import axis_out_arbiter_pkg::*;

    typedef struct {
        logic [W_BEAT-1:0] data;
        logic              last;
        logic              last_pkt;
        logic [W_BPT-1:0]  bpt;
        int                gap;
    } beat_t;

    typedef struct {
        logic [W_BEAT-1:0] data;
        logic [W_SRC-1:0]  src;
        logic              last;
        logic              last_pkt;
        logic [W_BPT-1:0]  bpt;
    } exp_t;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic [W_SRC-1:0] m_src;
    logic             layer_done;
    logic             err_bpt;

    axis_out_arbiter_if #(.LANES(N_SRC), .DW(W_BEAT), .BW(W_BPT)) s_axis ();
    axis_out_arbiter_if #(.LANES(1),     .DW(W_BEAT), .BW(W_BPT)) m_axis ();

    axis_out_arbiter dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s_axis     (s_axis),
        .m_axis     (m_axis),
        .m_src      (m_src),
        .layer_done (layer_done),
        .err_bpt    (err_bpt)
    );

    always #5 aclk = ~aclk;

    beat_t            srcq[N_SRC][$];
    exp_t             exp_q[$];
    int               n_cmp = 0;
    int               n_err = 0;
    bit               rst_req = 1'b1;
    int               ready_mode = 0;
    bit               tgl = 1'b0;
    bit [N_SRC-1:0]   pres;

    // reference model state
    bit               md_busy;
    int               md_grant;
    int               md_ptr;
    bit [N_SRC-1:0]   md_done;
    bit               md_err;
    bit               md_first;
    logic [W_BPT-1:0] md_bpt;
    beat_t            md_pkt[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    task automatic add_pkt(input int src, input int nb, input logic [W_BPT-1:0] bpt,
                           input bit lp, input int gap, input int chg_beat,
                           input logic [W_BPT-1:0] bpt2, input bit stray);
        beat_t x;
        for (int b = 0; b < nb; b++) begin
            x.data     = W_BEAT'($urandom);
            x.last     = (b == nb - 1);
            x.last_pkt = (lp && b == nb - 1) || (stray && b == 0 && nb > 1);
            x.bpt      = (chg_beat > 0 && b >= chg_beat) ? bpt2 : bpt;
            x.gap      = (b == 0) ? gap : 0;
            srcq[src].push_back(x);
        end
    endtask

    function automatic bit idle_all();
        for (int i = 0; i < N_SRC; i++) begin
            if (srcq[i].size() != 0) return 1'b0;
        end
        return !md_busy && exp_q.size() == 0;
    endfunction

    // Model of one clock: check what the DUT should show now, then advance by the rules.
    task automatic model_step();
        bit               full;
        int               w;
        logic [N_SRC-1:0] exp_rdy;
        logic [N_SRC-1:0] oh;
        exp_t             e;
        beat_t            b;
        if (!aresetn) begin
            chk("rst_m_valid", m_axis.valid, 0);
            chk("rst_s_ready", s_axis.ready, 0);
            chk("rst_layer_done", layer_done, 0);
            chk("rst_err_bpt", err_bpt, 0);
            md_busy = 0; md_grant = 0; md_ptr = 0; md_done = '0;
            md_err = 0; md_first = 0; md_bpt = '0;
            md_pkt.delete();
            exp_q.delete();
            return;
        end
        full = (md_done == {N_SRC{1'b1}});
        chk("layer_done", layer_done, full);
        chk("err_bpt", err_bpt, md_err);
        chk("m_valid", m_axis.valid, md_busy && pres[md_grant]);
        exp_rdy = '0;
        if (md_busy && m_axis.ready[0]) exp_rdy[md_grant] = 1'b1;
        chk("s_ready", s_axis.ready, exp_rdy);
        if (md_busy) chk("m_src_grant", m_src, md_grant);

        if (!md_busy) begin
            if (full) begin
                md_done = '0;
            end else begin
                w = -1;
                for (int k = 0; k < N_SRC; k++) begin
                    if (w < 0 && pres[(md_ptr + k) % N_SRC] && !md_done[(md_ptr + k) % N_SRC])
                        w = (md_ptr + k) % N_SRC;
                end
                if (w >= 0) begin
                    md_busy = 1; md_grant = w; md_first = 1;
                    oh = '0; oh[w] = 1'b1;
                    for (int i = 0; i < srcq[w].size(); i++) begin
                        md_pkt.push_back(srcq[w][i]);
                        e.data     = srcq[w][i].data;
                        e.src      = W_SRC'(w);
                        e.last     = srcq[w][i].last;
                        e.bpt      = srcq[w][i].bpt;
                        e.last_pkt = srcq[w][i].last && srcq[w][i].last_pkt
                                     && ((md_done | oh) == {N_SRC{1'b1}});
                        exp_q.push_back(e);
                        if (srcq[w][i].last) break;
                    end
                end
            end
        end else if (pres[md_grant] && m_axis.ready[0]) begin
            b = md_pkt.pop_front();
            if (md_first) md_bpt = b.bpt;
            else if (b.bpt != md_bpt) md_err = 1;
            md_first = 0;
            if (b.last) begin
                md_busy = 0;
                md_ptr  = (md_grant + 1) % N_SRC;
                if (b.last_pkt) md_done[md_grant] = 1'b1;
            end
        end
    endtask

    // One clock: drive at negedge, model at +1, accept handshakes just before the posedge.
    task automatic cycle();
        beat_t h;
        @(negedge aclk);
        aresetn = !rst_req;
        for (int i = 0; i < N_SRC; i++) begin
            pres[i] = 1'b0;
            s_axis.data[i*W_BEAT +: W_BEAT] = W_BEAT'($urandom);
            s_axis.last[i]                  = 1'($urandom);
            s_axis.last_pkt[i]              = 1'($urandom);
            s_axis.bpt[i*W_BPT +: W_BPT]    = W_BPT'($urandom);
            if (!rst_req && srcq[i].size() != 0) begin
                if (srcq[i][0].gap > 0) begin
                    h = srcq[i][0];
                    h.gap--;
                    srcq[i][0] = h;
                end else begin
                    pres[i] = 1'b1;
                    s_axis.data[i*W_BEAT +: W_BEAT] = srcq[i][0].data;
                    s_axis.last[i]                  = srcq[i][0].last;
                    s_axis.last_pkt[i]              = srcq[i][0].last_pkt;
                    s_axis.bpt[i*W_BPT +: W_BPT]    = srcq[i][0].bpt;
                end
            end
        end
        s_axis.valid = pres;
        case (ready_mode)
            1:       begin tgl = !tgl; m_axis.ready = tgl; end
            2:       m_axis.ready = ($urandom_range(0, 3) != 0);
            default: m_axis.ready = 1'b1;
        endcase
        #1;
        model_step();
        #3;
        if (aresetn) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (s_axis.valid[i] && s_axis.ready[i]) void'(srcq[i].pop_front());
            end
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < N_SRC; i++) srcq[i].delete();
        rst_req = 1'b1;
        repeat (n) cycle();
        rst_req = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget && !idle_all()) begin
            cycle();
            n++;
        end
        n_cmp++;
        if (n >= budget) begin
            n_err++;
            $display("FAIL drain_%s: still busy after %0d cycles, %0d beats outstanding",
                     name, n, exp_q.size());
        end
        repeat (3) cycle();
    endtask

    // Monitor: every presented output beat must match the head of the expected queue.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge aclk);
            #2;
            if (aresetn && m_axis.valid[0]) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat @%0t: got src %0d data %0h, want none",
                             $time, m_src, m_axis.data);
                end else begin
                    e = exp_q[0];
                    chk("m_data", m_axis.data, e.data);
                    chk("m_src", m_src, e.src);
                    chk("m_last", m_axis.last, e.last);
                    chk("m_last_pkt", m_axis.last_pkt, e.last_pkt);
                    chk("m_bpt", m_axis.bpt, e.bpt);
                    if (m_axis.ready[0]) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int nb;
        int np;
        int chg;
        logic [W_BPT-1:0] bsel [3];
        bsel[0] = 8'd16; bsel[1] = 8'd32; bsel[2] = 8'd64;
        s_axis.valid = '0;
        m_axis.ready = 1'b1;
        do_reset(2);

        // single source, 3 beats
        add_pkt(0, 3, 8'd16, 0, 0, 0, 8'd0, 0);
        drain("single", 50);

        // all sources, two 2-beat packets each
        do_reset(1);
        for (int s = 0; s < N_SRC; s++) begin
            add_pkt(s, 2, 8'd16, 0, 0, 0, 8'd0, 0);
            add_pkt(s, 2, 8'd16, 0, 0, 0, 8'd0, 0);
        end
        drain("all_rr", 100);

        // toggling m_ready on a 4-beat packet from source 2
        ready_mode = 1; tgl = 1'b0;
        add_pkt(2, 4, 8'd32, 0, 0, 0, 8'd0, 0);
        drain("toggle", 50);
        ready_mode = 0;

        // layer barrier: source 1 closes its layer first and keeps data queued
        do_reset(1);
        add_pkt(1, 1, 8'd16, 1, 0, 0, 8'd0, 0);
        add_pkt(1, 2, 8'd16, 0, 0, 0, 8'd0, 0);
        for (int s = 0; s < N_SRC; s++) begin
            if (s != 1) begin
                add_pkt(s, 2, 8'd16, 0, 4, 0, 8'd0, 0);
                add_pkt(s, 1, 8'd16, 1, 0, 0, 8'd0, 0);
            end
        end
        drain("barrier", 200);

        // bpt change inside a packet, then clean packets keep the sticky error
        add_pkt(3, 3, 8'd16, 0, 0, 1, 8'd32, 0);
        add_pkt(0, 2, 8'd64, 0, 2, 0, 8'd0, 0);
        add_pkt(1, 2, 8'd64, 0, 2, 0, 8'd0, 0);
        drain("bpt", 100);

        // reset on beat 2 of 4 from source 2, after source 1 moved the pointer
        do_reset(1);
        add_pkt(1, 1, 8'd16, 0, 0, 0, 8'd0, 0);
        drain("pre_rst", 50);
        add_pkt(2, 4, 8'd16, 0, 0, 0, 8'd0, 0);
        for (int n = 0; n < 20 && srcq[2].size() > 3; n++) cycle();
        chk("reset_mid_reach", srcq[2].size(), 3);
        do_reset(1);
        for (int s = 0; s < N_SRC; s++) add_pkt(s, 2, 8'd16, 0, 0, 0, 8'd0, 0);
        drain("post_rst", 100);

        // randomized layers with random backpressure
        do_reset(1);
        ready_mode = 2;
        for (int layer = 0; layer < 12; layer++) begin
            for (int s = 0; s < N_SRC; s++) begin
                np = $urandom_range(1, 3);
                for (int p = 0; p < np; p++) begin
                    nb  = $urandom_range(1, 4);
                    chg = (nb > 1 && $urandom_range(0, 19) == 0) ? $urandom_range(1, nb - 1) : 0;
                    add_pkt(s, nb, bsel[$urandom_range(0, 2)], p == np - 1,
                            $urandom_range(0, 3), chg, 8'd128, $urandom_range(0, 9) == 0);
                end
            end
        end
        drain("random", 20000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
